seven_seg_scan_capture: RTL and testbench

Receiving end of the multiplexed seven-segment scan interface. Monitors the active-low anode strobes, cathode segment lines and decimal point as driven to the display. For each strobed digit it waits for stable levels, decodes the segment pattern back to a hex nibble, and stores it per digit position. Used for on-board loopback self-test of the display path and for bench checking of the scan controller and segment encoder.

---
 rtl/seven_seg_scan_capture_if.sv | 21 ++
 rtl/seven_seg_scan_capture.sv | 161 ++++++++++++++++
 tb/tb_seven_seg_scan_capture.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_capture_if.sv
// Seven-segment scan bus: display pins observed by the capture block, plus its decoded results.
interface seven_seg_scan_capture_if;
  logic [7:0]  Annode;
  logic [6:0]  Cathode;
  logic        Dp;
  logic [31:0] HexOut;
  logic [7:0]  DigitValid;
  logic [7:0]  DpOut;
  logic        FrameDone;
  logic        ScanError;

  modport master (
    output Annode, Cathode, Dp,
    input  HexOut, DigitValid, DpOut, FrameDone, ScanError
  );

  modport slave (
    input  Annode, Cathode, Dp,
    output HexOut, DigitValid, DpOut, FrameDone, ScanError
  );
endinterface

// File: rtl/seven_seg_scan_capture.sv
// Captures each stably strobed seven-segment digit, decodes it back to hex and
// reports completed frames and illegal multi-anode strobes.
module seven_seg_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  seven_seg_scan_capture_if.slave  bus
);

  localparam int unsigned PIN_W = 16;
  localparam int unsigned NDIG  = 8;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [PIN_W-1:0]  pins_c;
  logic [PIN_W-1:0]  sample;
  logic              changed_c;
  logic [CNT_W-1:0]  cnt;

  logic [31:0]       hex_q, hex_d;
  logic [NDIG-1:0]   valid_q, valid_d;
  logic [NDIG-1:0]   dp_q, dp_d;
  logic [NDIG-1:0]   seen_q, seen_d;
  logic              frame_q, frame_d;
  logic              err_q, err_d;

  assign pins_c    = {bus.Annode, bus.Cathode, bus.Dp};
  assign changed_c = (pins_c != sample);

  // Map active-low cathode pins back to {legal, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] cath);
    logic [6:0] seg;
    seg = ~cath;
    case (seg)
      7'h3F:   decode = {1'b1, 4'h0};
      7'h06:   decode = {1'b1, 4'h1};
      7'h5B:   decode = {1'b1, 4'h2};
      7'h4F:   decode = {1'b1, 4'h3};
      7'h66:   decode = {1'b1, 4'h4};
      7'h6D:   decode = {1'b1, 4'h5};
      7'h7D:   decode = {1'b1, 4'h6};
      7'h07:   decode = {1'b1, 4'h7};
      7'h7F:   decode = {1'b1, 4'h8};
      7'h6F:   decode = {1'b1, 4'h9};
      7'h77:   decode = {1'b1, 4'hA};
      7'h7C:   decode = {1'b1, 4'hB};
      7'h39:   decode = {1'b1, 4'hC};
      7'h5E:   decode = {1'b1, 4'hD};
      7'h79:   decode = {1'b1, 4'hE};
      7'h71:   decode = {1'b1, 4'hF};
      default: decode = 5'h00;
    endcase
  endfunction

  // Input register and stability counter; change is judged against the live pins
  // so the counter reaches STABLE_CYCLES exactly when capture is entered.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sample <= '0;
      cnt    <= '0;
    end else begin
      sample <= pins_c;
      if (changed_c)
        cnt <= '0;
      else if (cnt != CNT_W'(STABLE_CYCLES))
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= WAIT;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      WAIT:    if (changed_c) state_d = SETTLE;
      SETTLE:  if (changed_c) state_d = SETTLE;
               else if (cnt == CNT_W'(STABLE_CYCLES - 1)) state_d = CAPTURE;
      CAPTURE: state_d = changed_c ? SETTLE : HOLD;
      HOLD:    if (changed_c) state_d = SETTLE;
      default: state_d = WAIT;
    endcase
  end

  // Capture action, classified by how many anodes are strobed.
  always_comb begin
    logic [NDIG-1:0] low;
    logic [NDIG-1:0] seen_nxt;
    logic [4:0]      dec;
    logic [2:0]      idx;
    logic            blank;
    logic            single;

    hex_d    = hex_q;
    valid_d  = valid_q;
    dp_d     = dp_q;
    seen_d   = seen_q;
    frame_d  = 1'b0;
    err_d    = 1'b0;
    low      = ~sample[15:8];
    dec      = decode(sample[7:1]);
    blank    = (low == '0);
    single   = !blank && ((low & (low - NDIG'(1))) == '0);
    idx      = 3'd0;
    seen_nxt = seen_q | low;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (low[i]) idx = 3'(i);
    end

    if (state == CAPTURE) begin
      if (single) begin
        hex_d[{idx, 2'b00} +: 4] = dec[3:0];
        valid_d[idx]             = dec[4];
        dp_d[idx]                = ~sample[0];
        if (seen_nxt == '1) begin
          frame_d = 1'b1;
          seen_d  = '0;
        end else begin
          seen_d  = seen_nxt;
        end
      end else if (!blank) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hex_q   <= '0;
      valid_q <= '0;
      dp_q    <= '0;
      seen_q  <= '0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      hex_q   <= hex_d;
      valid_q <= valid_d;
      dp_q    <= dp_d;
      seen_q  <= seen_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  assign bus.HexOut     = hex_q;
  assign bus.DigitValid = valid_q;
  assign bus.DpOut      = dp_q;
  assign bus.FrameDone  = frame_q;
  assign bus.ScanError  = err_q;

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// Directed bench for seven_seg_scan_capture with STABLE_CYCLES=4.
module tb_seven_seg_scan_capture;

  logic Clk = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  always #5 Clk = ~Clk;

  seven_seg_scan_capture_if bus ();

  seven_seg_scan_capture #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Active-low cathode pattern for a hex digit.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40; 4'h1: glyph = 7'h79; 4'h2: glyph = 7'h24; 4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19; 4'h5: glyph = 7'h12; 4'h6: glyph = 7'h02; 4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00; 4'h9: glyph = 7'h10; 4'hA: glyph = 7'h08; 4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46; 4'hD: glyph = 7'h21; 4'hE: glyph = 7'h06; default: glyph = 7'h0E;
    endcase
  endfunction

  task automatic drive(input logic [7:0] an, input logic [6:0] ca, input logic dp);
    @(negedge Clk);
    bus.Annode  = an;
    bus.Cathode = ca;
    bus.Dp      = dp;
  endtask

  task automatic hold(input int n, output int fd, output int se);
    fd = 0;
    se = 0;
    repeat (n) begin
      @(negedge Clk);
      if (bus.FrameDone === 1'b1) fd++;
      if (bus.ScanError === 1'b1) se++;
    end
  endtask

  task automatic scan(input int d, input logic [3:0] v, output int fd, output int se);
    logic [7:0] an;
    an = 8'h01 << d;
    drive(~an, glyph(v), 1'b1);
    hold(10, fd, se);
  endtask

  task automatic pulse_reset();
    drive(8'hFF, 7'h7F, 1'b1);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.Annode = 8'hFF; bus.Cathode = 7'h7F; bus.Dp = 1'b1;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    checks++; if (bus.HexOut !== 32'h0) begin errors++; $display("FAIL reset_hex got=%h exp=0", bus.HexOut); end
    checks++; if (bus.DigitValid !== 8'h0) begin errors++; $display("FAIL reset_valid got=%h exp=0", bus.DigitValid); end
    checks++; if (bus.DpOut !== 8'h0) begin errors++; $display("FAIL reset_dp got=%h exp=0", bus.DpOut); end
    checks++; if ({bus.FrameDone, bus.ScanError} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {bus.FrameDone, bus.ScanError}); end
    Reset = 1'b0;
  endtask

  task automatic test_frame();
    int fd, se, fd_tot, se_tot;
    fd_tot = 0; se_tot = 0;
    for (int d = 0; d < 7; d++) begin
      scan(d, 4'(d), fd, se);
      fd_tot += fd; se_tot += se;
    end
    checks++; if (fd_tot !== 0 || se_tot !== 0) begin errors++; $display("FAIL frame_early got fd=%0d se=%0d exp 0 0", fd_tot, se_tot); end
    drive(8'h7F, glyph(4'h7), 1'b1);
    repeat (5) @(negedge Clk);
    checks++; if (bus.FrameDone !== 1'b0 || bus.HexOut !== 32'h06543210) begin errors++; $display("FAIL frame_latency_early fd=%b hex=%h exp 0 06543210", bus.FrameDone, bus.HexOut); end
    @(negedge Clk);
    checks++; if (bus.FrameDone !== 1'b1 || bus.HexOut !== 32'h76543210) begin errors++; $display("FAIL frame_latency fd=%b hex=%h exp 1 76543210", bus.FrameDone, bus.HexOut); end
    @(negedge Clk);
    checks++; if (bus.FrameDone !== 1'b0) begin errors++; $display("FAIL frame_pulse_width fd=%b exp 0", bus.FrameDone); end
    hold(5, fd, se);
    checks++; if (fd !== 0) begin errors++; $display("FAIL frame_single got=%0d exp 0 extra", fd); end
    checks++; if (bus.DigitValid !== 8'hFF || bus.DpOut !== 8'h00) begin errors++; $display("FAIL frame_valid got v=%h dp=%h exp FF 00", bus.DigitValid, bus.DpOut); end
  endtask

  task automatic test_decode_dp();
    int fd, se;
    drive(8'hFE, 7'h00, 1'b0);
    hold(10, fd, se);
    checks++; if (bus.HexOut !== 32'h76543218 || bus.DpOut !== 8'h01) begin errors++; $display("FAIL decode_eight hex=%h dp=%h exp 76543218 01", bus.HexOut, bus.DpOut); end
    drive(8'hFE, 7'h7F, 1'b0);
    hold(10, fd, se);
    checks++; if (bus.HexOut !== 32'h76543210 || bus.DigitValid !== 8'hFE) begin errors++; $display("FAIL decode_blank hex=%h v=%h exp 76543210 FE", bus.HexOut, bus.DigitValid); end
  endtask

  task automatic test_scan_error();
    int fd, se;
    drive(8'hFC, 7'h00, 1'b1);
    hold(10, fd, se);
    checks++; if (se !== 1 || bus.HexOut !== 32'h76543210) begin errors++; $display("FAIL scan_error se=%0d hex=%h exp 1 76543210", se, bus.HexOut); end
    drive(8'hFF, 7'h00, 1'b1);
    hold(10, fd, se);
    checks++; if (se !== 0 || fd !== 0 || bus.HexOut !== 32'h76543210) begin errors++; $display("FAIL blank_anodes se=%0d fd=%0d hex=%h exp 0 0 76543210", se, fd, bus.HexOut); end
  endtask

  task automatic test_glitch();
    int fd, se, fd_tot, se_tot;
    fd_tot = 0; se_tot = 0;
    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 0) ? 8'hFE : 8'hFD, glyph(4'h5), 1'b1);
      hold(1, fd, se);
      fd_tot += fd; se_tot += se;
    end
    drive(8'hFF, 7'h7F, 1'b1);
    hold(10, fd, se);
    fd_tot += fd; se_tot += se;
    checks++; if (bus.HexOut !== 32'h76543210 || bus.DigitValid !== 8'hFE) begin errors++; $display("FAIL glitch_capture hex=%h v=%h exp 76543210 FE", bus.HexOut, bus.DigitValid); end
    checks++; if (fd_tot !== 0 || se_tot !== 0) begin errors++; $display("FAIL glitch_pulses fd=%0d se=%0d exp 0 0", fd_tot, se_tot); end
  endtask

  task automatic test_reset_mid_frame();
    int fd, se, fd_tot;
    for (int d = 0; d < 6; d++) scan(d, 4'(d + 9), fd, se);
    checks++; if (bus.HexOut !== 32'h76EDCBA9) begin errors++; $display("FAIL partial_hex got=%h exp 76EDCBA9", bus.HexOut); end
    pulse_reset();
    checks++; if (bus.HexOut !== 32'h0 || bus.DigitValid !== 8'h0) begin errors++; $display("FAIL midreset_clear hex=%h v=%h exp 0 0", bus.HexOut, bus.DigitValid); end
    fd_tot = 0;
    scan(6, 4'h1, fd, se); fd_tot += fd;
    scan(7, 4'h2, fd, se); fd_tot += fd;
    checks++; if (fd_tot !== 0 || bus.HexOut !== 32'h21000000 || bus.DigitValid !== 8'hC0) begin errors++; $display("FAIL after_reset fd=%0d hex=%h v=%h exp 0 21000000 C0", fd_tot, bus.HexOut, bus.DigitValid); end
    fd_tot = 0;
    for (int d = 0; d < 8; d++) begin
      scan(d, 4'(15 - d), fd, se);
      fd_tot += fd;
    end
    checks++; if (fd_tot !== 1 || bus.HexOut !== 32'h89ABCDEF) begin errors++; $display("FAIL full_after_reset fd=%0d hex=%h exp 1 89ABCDEF", fd_tot, bus.HexOut); end
  endtask

  task automatic test_back_to_back();
    int fd, se, fd_tot;
    pulse_reset();
    fd_tot = 0;
    scan(3, 4'hA, fd, se); fd_tot += fd;
    checks++; if (bus.HexOut[15:12] !== 4'hA) begin errors++; $display("FAIL recap_first got=%h exp A", bus.HexOut[15:12]); end
    scan(3, 4'hF, fd, se); fd_tot += fd;
    for (int d = 0; d < 7; d++) begin
      if (d != 3) begin
        scan(d, 4'(d), fd, se);
        fd_tot += fd;
      end
    end
    checks++; if (fd_tot !== 0) begin errors++; $display("FAIL recap_early_frame got=%0d exp 0", fd_tot); end
    scan(7, 4'h7, fd, se);
    checks++; if (fd !== 1 || bus.HexOut !== 32'h7654F210) begin errors++; $display("FAIL recap_frame fd=%0d hex=%h exp 1 7654F210", fd, bus.HexOut); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_decode_dp();
    test_scan_error();
    test_glitch();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
